route_lookup_ctrl: RTL and testbench
====================================

// Module: route_lookup_ctrl
// PURPOSE
//  Front-end sequencer for the route TCAM: accepts destination-IP lookup requests and route-table updates, drives TCAM
//  addr/wr_en/wr_index, waits out TCAM latency, returns tagged forwarding results to egress via valid/ready.
//  Sits between ingress header parser (upstream) and TCAM; sole owner of the TCAM port.
// PARAMETERS
//  TAG_W        8    request tag width, echoed unchanged on response
//  LOOKUP_WAIT  2    clk edges from tcam_addr_in change to sampling tcam_addr_out/prefix_size/if_idx/valid (min 2)
//  DEFAULT_IF   4'hF if_idx returned on miss
// PORTS
//  clk             in   1      single clock, all logic on posedge
//  rst             in   1      synchronous reset, active-high
//  req_valid/ready in/out 1    lookup request handshake
//  req_dst_ip      in   32     destination IPv4 address
//  req_tag         in   TAG_W  opaque request id
//  upd_valid/ready in/out 1    table update handshake
//  upd_index       in   8      TCAM entry index
//  upd_prefix      in   32     route prefix
//  upd_mask        in   32     netmask
//  upd_if_idx      in   4      egress interface
//  tcam_addr_in    out  68     {if_idx[3:0], mask[31:0], prefix/IP[31:0]}; lookups drive {4'h0, 32'h0, dst_ip}
//  tcam_wr_en      out  1      TCAM write strobe
//  tcam_wr_index   out  8      TCAM write index
//  tcam_addr_out   in   32     matched prefix
//  tcam_prefix_size in  8      matched prefix length
//  tcam_if_idx     in   4      matched interface
//  tcam_valid      in   1      match found
//  rsp_valid/ready out/in 1    response handshake
//  rsp_tag/rsp_hit out  TAG_W/1 echoed tag; 1 = route matched
//  rsp_if_idx      out  4      tcam_if_idx on hit, DEFAULT_IF on miss
//  rsp_prefix      out  32     matched prefix (0 on miss)
//  rsp_prefix_len  out  8      matched length (0 on miss)
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=upd_ready=rsp_valid=tcam_wr_en=0; tcam_addr_in, tcam_wr_index, rsp_* data = 0; wait cnt 0.
//  - FSM IDLE -> WRITE | LOOKUP; WRITE -> IDLE; LOOKUP -> RESP; RESP -> IDLE on rsp_valid&&rsp_ready.
//  - req_ready/upd_ready are 1 only in IDLE, combinationally with the arbitration grant; at most one accepted per cycle.
//  - Arbitration in IDLE: both pending -> update wins unless previous grant was an update (alternate; no starvation).
//  - WRITE: exactly 1 cycle, tcam_wr_en=1, tcam_wr_index=upd_index, tcam_addr_in={upd_if_idx,upd_mask,upd_prefix}; wr_en=0 next.
//  - LOOKUP: tcam_addr_in registered on accept; counter counts LOOKUP_WAIT edges with wr_en=0; then capture TCAM outputs.
//  - Capture: tcam_valid=1 -> hit=1, fields from TCAM; 0 -> hit=0, if_idx=DEFAULT_IF, prefix=0, len=0.
//  - RESP: rsp_valid=1, rsp_* held stable until rsp_ready; no new accept while rsp_valid=1 (backpressure stalls both inputs).
//  - Min request-to-rsp_valid latency LOOKUP_WAIT+1 cycles; back-to-back throughput one lookup per LOOKUP_WAIT+2 cycles.
//  - Write during lookup impossible by construction (no preemption); an update always completes before any later lookup is issued.
//  - Reset mid-LOOKUP/RESP: in-flight lookup dropped, no response; mid-WRITE: wr_en forced 0 on that edge.
// CONFIGURATION
//  - ROUTE_LOOKUP_STATS_EN defined: extra ports stat_hits, stat_misses, stat_updates (out, 32 each), saturating at
//    32'hFFFF_FFFF, increment on capture/hit, capture/miss, WRITE entry; cleared by rst.
//  - Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package route_pkg: IP_W=32, IF_W=4, IDX_W=8, TCAM_W=68, state enum {IDLE,WRITE,LOOKUP,RESP}, entry pack function.
//  - Sub-module route_sat_counter (32-bit saturating, sync clear), instantiated 3x only under ROUTE_LOOKUP_STATS_EN.
// TESTING
//  - Update idx 3: prefix 0A000000 mask FF000000 if 2 -> one-cycle wr_en=1, wr_index=3, addr_in=2_FF000000_0A000000.
//  - Lookup 0A010203 tag 5A with /8 route present -> rsp after LOOKUP_WAIT+1: hit=1 if=2 prefix=0A000000 len=8 tag=5A.
//  - Lookup C0A80001 with no match -> hit=0, rsp_if_idx=F, prefix=0, len=0.
//  - upd_valid and req_valid both high in IDLE twice -> grants update, lookup, update; lookup sees new entry.
//  - rsp_ready low 10 cycles -> rsp_* stable, req_ready=upd_ready=0 throughout; accepted once ready rises.
//  - rst pulsed during LOOKUP -> no rsp_valid, outputs zero; STATS_EN build: counters 0, then hit/miss counts exact.

Source files
------------

// File: rtl/route_pkg.sv
// route_pkg: shared widths, FSM state type and TCAM entry packing for the route lookup front-end.
package route_pkg;

  localparam int unsigned IP_W   = 32;
  localparam int unsigned IF_W   = 4;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned TCAM_W = IF_W + IP_W + IP_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    LOOKUP = 2'd2,
    RESP   = 2'd3
  } state_t;

  // TCAM key/entry layout: {if_idx, mask, prefix}
  typedef struct packed {
    logic [IF_W-1:0] if_idx;
    logic [IP_W-1:0] mask;
    logic [IP_W-1:0] prefix;
  } tcam_entry_t;

  // Build the TCAM port word from its fields
  function automatic logic [TCAM_W-1:0] pack_entry(
    input logic [IF_W-1:0] if_idx,
    input logic [IP_W-1:0] mask,
    input logic [IP_W-1:0] prefix
  );
    tcam_entry_t e;
    e.if_idx = if_idx;
    e.mask   = mask;
    e.prefix = prefix;
    return e;
  endfunction

endpackage

// File: rtl/route_sat_counter.sv
// route_sat_counter: saturating event counter with synchronous clear.
module route_sat_counter
  import route_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, hold at all-ones, clear synchronously
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/route_lookup_ctrl.sv
// route_lookup_ctrl: sequences lookups and table updates onto the route TCAM port.
// Optional statistics counters are built when ROUTE_LOOKUP_STATS_EN is defined.
module route_lookup_ctrl
  import route_pkg::*;
#(
  parameter int unsigned     TAG_W       = 8,
  parameter int unsigned     LOOKUP_WAIT = 2,
  parameter logic [IF_W-1:0] DEFAULT_IF  = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IP_W-1:0]   req_dst_ip,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [IDX_W-1:0]  upd_index,
  input  logic [IP_W-1:0]   upd_prefix,
  input  logic [IP_W-1:0]   upd_mask,
  input  logic [IF_W-1:0]   upd_if_idx,
  output logic [TCAM_W-1:0] tcam_addr_in,
  output logic              tcam_wr_en,
  output logic [IDX_W-1:0]  tcam_wr_index,
  input  logic [IP_W-1:0]   tcam_addr_out,
  input  logic [LEN_W-1:0]  tcam_prefix_size,
  input  logic [IF_W-1:0]   tcam_if_idx,
  input  logic              tcam_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_hit,
  output logic [IF_W-1:0]   rsp_if_idx,
  output logic [IP_W-1:0]   rsp_prefix,
  output logic [LEN_W-1:0]  rsp_prefix_len
`ifdef ROUTE_LOOKUP_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_updates
`endif
);

  localparam int unsigned CNT_W = (LOOKUP_WAIT > 2) ? $clog2(LOOKUP_WAIT) : 1;

  state_t             state;
  state_t             state_nxt;
  logic               grant_upd;
  logic               grant_req;
  logic               capture;
  logic               last_upd;
  logic [CNT_W-1:0]   wait_cnt;
  logic [TAG_W-1:0]   pend_tag;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, arbitration grant and capture strobe
  always_comb begin
    state_nxt = state;
    grant_upd = 1'b0;
    grant_req = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (upd_valid && (!req_valid || !last_upd)) begin
            grant_upd = 1'b1;
            state_nxt = WRITE;
          end else if (req_valid) begin
            grant_req = 1'b1;
            state_nxt = LOOKUP;
          end
        end
      end
      WRITE: state_nxt = IDLE;
      LOOKUP: begin
        if (wait_cnt == CNT_W'(LOOKUP_WAIT - 1)) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = grant_req;
  assign upd_ready = grant_upd;

  // TCAM drive, latency counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tcam_addr_in   <= '0;
      tcam_wr_en     <= 1'b0;
      tcam_wr_index  <= '0;
      rsp_valid      <= 1'b0;
      rsp_tag        <= '0;
      rsp_hit        <= 1'b0;
      rsp_if_idx     <= '0;
      rsp_prefix     <= '0;
      rsp_prefix_len <= '0;
      wait_cnt       <= '0;
      pend_tag       <= '0;
      last_upd       <= 1'b0;
    end else begin
      tcam_wr_en <= 1'b0;
      if (grant_upd) begin
        tcam_wr_en    <= 1'b1;
        tcam_wr_index <= upd_index;
        tcam_addr_in  <= pack_entry(upd_if_idx, upd_mask, upd_prefix);
        last_upd      <= 1'b1;
      end
      if (grant_req) begin
        tcam_addr_in <= pack_entry(IF_W'(0), IP_W'(0), req_dst_ip);
        pend_tag     <= req_tag;
        wait_cnt     <= '0;
        last_upd     <= 1'b0;
      end
      if (state == LOOKUP) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_tag   <= pend_tag;
        if (tcam_valid) begin
          rsp_hit        <= 1'b1;
          rsp_if_idx     <= tcam_if_idx;
          rsp_prefix     <= tcam_addr_out;
          rsp_prefix_len <= tcam_prefix_size;
        end else begin
          rsp_hit        <= 1'b0;
          rsp_if_idx     <= DEFAULT_IF;
          rsp_prefix     <= '0;
          rsp_prefix_len <= '0;
        end
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ROUTE_LOOKUP_STATS_EN
  // Hit / miss / update statistics
  route_sat_counter #(.W(32)) u_hits (
    .clk   (clk),
    .clr   (rst),
    .inc   (capture && tcam_valid),
    .count (stat_hits)
  );

  route_sat_counter #(.W(32)) u_misses (
    .clk   (clk),
    .clr   (rst),
    .inc   (capture && !tcam_valid),
    .count (stat_misses)
  );

  route_sat_counter #(.W(32)) u_updates (
    .clk   (clk),
    .clr   (rst),
    .inc   (grant_upd),
    .count (stat_updates)
  );
`endif

endmodule

// File: tb/tb_route_lookup_ctrl.sv
// tb_route_lookup_ctrl: directed and randomized checks of route_lookup_ctrl against a longest-prefix route model.
// Build with ROUTE_LOOKUP_STATS_EN defined to also check the statistics counters.
module tb_route_lookup_ctrl;

  localparam int unsigned LW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_dst_ip;
  logic [7:0]  req_tag;
  logic        upd_valid, upd_ready;
  logic [7:0]  upd_index;
  logic [31:0] upd_prefix, upd_mask;
  logic [3:0]  upd_if_idx;
  logic [67:0] tcam_addr_in;
  logic        tcam_wr_en;
  logic [7:0]  tcam_wr_index;
  logic [31:0] tcam_addr_out;
  logic [7:0]  tcam_prefix_size;
  logic [3:0]  tcam_if_idx;
  logic        tcam_valid;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_tag;
  logic        rsp_hit;
  logic [3:0]  rsp_if_idx;
  logic [31:0] rsp_prefix;
  logic [7:0]  rsp_prefix_len;
`ifdef ROUTE_LOOKUP_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_updates;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_hits = 0, exp_misses = 0, exp_upd = 0;

  // Reference route table: prefix length based, independent of mask encoding
  bit          ref_v   [256];
  logic [7:0]  ref_len [256];
  logic [31:0] ref_pfx [256];
  logic [3:0]  ref_if  [256];

  // TCAM stand-in table, written only through the DUT write port
  bit          st_v [256];
  logic [67:0] st_e [256];

  route_lookup_ctrl #(.TAG_W(8), .LOOKUP_WAIT(LW), .DEFAULT_IF(4'hF)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_dst_ip       (req_dst_ip),
    .req_tag          (req_tag),
    .upd_valid        (upd_valid),
    .upd_ready        (upd_ready),
    .upd_index        (upd_index),
    .upd_prefix       (upd_prefix),
    .upd_mask         (upd_mask),
    .upd_if_idx       (upd_if_idx),
    .tcam_addr_in     (tcam_addr_in),
    .tcam_wr_en       (tcam_wr_en),
    .tcam_wr_index    (tcam_wr_index),
    .tcam_addr_out    (tcam_addr_out),
    .tcam_prefix_size (tcam_prefix_size),
    .tcam_if_idx      (tcam_if_idx),
    .tcam_valid       (tcam_valid),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_tag          (rsp_tag),
    .rsp_hit          (rsp_hit),
    .rsp_if_idx       (rsp_if_idx),
    .rsp_prefix       (rsp_prefix),
    .rsp_prefix_len   (rsp_prefix_len)
`ifdef ROUTE_LOOKUP_STATS_EN
    ,
    .stat_hits        (stat_hits),
    .stat_misses      (stat_misses),
    .stat_updates     (stat_updates)
`endif
  );

  always #5 clk = ~clk;

  // TCAM stand-in: one register stage of masked-match LPM; garbage data on miss
  always @(posedge clk) begin : tcam_stub
    int best_i;
    int best_l;
    best_i = -1;
    best_l = -1;
    for (int i = 0; i < 256; i++) begin
      if (st_v[i] && ((tcam_addr_in[31:0] & st_e[i][63:32]) == (st_e[i][31:0] & st_e[i][63:32]))
          && ($countones(st_e[i][63:32]) > best_l)) begin
        best_i = i;
        best_l = $countones(st_e[i][63:32]);
      end
    end
    if (best_i >= 0) begin
      tcam_valid       <= 1'b1;
      tcam_addr_out    <= st_e[best_i][31:0];
      tcam_prefix_size <= 8'(best_l);
      tcam_if_idx      <= st_e[best_i][67:64];
    end else begin
      tcam_valid       <= 1'b0;
      tcam_addr_out    <= $urandom;
      tcam_prefix_size <= 8'($urandom);
      tcam_if_idx      <= 4'($urandom);
    end
    if (tcam_wr_en) begin
      st_v[tcam_wr_index] <= 1'b1;
      st_e[tcam_wr_index] <= tcam_addr_in;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] len2mask(input int unsigned len);
    return (len == 0) ? 32'h0 : (32'hFFFF_FFFF << (32 - len));
  endfunction

  // Longest matching prefix over the reference table; lowest index wins ties
  function automatic void ref_lookup(input logic [31:0] ip, output logic hit, output logic [3:0] ifx,
                                     output logic [31:0] pfx, output logic [7:0] len);
    int best;
    best = -1;
    hit = 1'b0; ifx = 4'hF; pfx = 32'h0; len = 8'h0;
    for (int i = 0; i < 256; i++) begin
      if (ref_v[i]) begin
        int sh;
        sh = 32 - int'(ref_len[i]);
        if (((ip >> sh) == (ref_pfx[i] >> sh)) && (int'(ref_len[i]) > best)) begin
          best = int'(ref_len[i]);
          hit = 1'b1; ifx = ref_if[i]; pfx = ref_pfx[i]; len = ref_len[i];
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) at negedges for a grant on the update or request side
  task automatic wait_grant(input bit upd);
    int k;
    k = 0;
    @(negedge clk);
    while (((upd ? upd_ready : req_ready) !== 1'b1) && (k < 40)) begin
      @(negedge clk);
      k++;
    end
    chk(upd ? "upd_grant" : "req_grant", upd ? upd_ready : req_ready, 68'd1);
  endtask

  // Called in the WRITE cycle right after an update was accepted
  task automatic upd_finish(input logic [7:0] idx, input logic [31:0] pfx, input int unsigned len,
                            input logic [3:0] ifx);
    chk("wr_en_hi", tcam_wr_en, 68'd1);
    chk("wr_index", tcam_wr_index, idx);
    chk("wr_entry", tcam_addr_in, {ifx, len2mask(len), pfx});
    ref_v[idx] = 1'b1; ref_len[idx] = 8'(len); ref_pfx[idx] = pfx; ref_if[idx] = ifx;
    exp_upd++;
    tick();
    chk("wr_en_lo", tcam_wr_en, 68'd0);
  endtask

  task automatic do_update(input logic [7:0] idx, input logic [31:0] pfx, input int unsigned len,
                           input logic [3:0] ifx);
    upd_index = idx; upd_prefix = pfx; upd_mask = len2mask(len); upd_if_idx = ifx; upd_valid = 1'b1;
    wait_grant(1'b1);
    tick();
    upd_valid = 1'b0;
    upd_finish(idx, pfx, len, ifx);
  endtask

  task automatic chk_rsp(input logic hit, input logic [3:0] ifx, input logic [31:0] pfx,
                         input logic [7:0] len, input logic [7:0] tag);
    chk("rsp_valid", rsp_valid, 68'd1);
    chk("rsp_tag", rsp_tag, tag);
    chk("rsp_hit", rsp_hit, hit);
    chk("rsp_if_idx", rsp_if_idx, ifx);
    chk("rsp_prefix", rsp_prefix, pfx);
    chk("rsp_prefix_len", rsp_prefix_len, len);
  endtask

  // Called one step after the accept edge: exact latency, stall stability, handshake
  task automatic lk_finish(input logic hit, input logic [3:0] ifx, input logic [31:0] pfx,
                           input logic [7:0] len, input logic [7:0] tag, input int stall, input bit hold);
    chk("lat_early", rsp_valid, 68'd0);
    for (int i = 1; i < int'(LW); i++) begin
      tick();
      chk("lat_early", rsp_valid, 68'd0);
    end
    tick();
    chk_rsp(hit, ifx, pfx, len, tag);
    if (hold) begin
      req_valid = 1'b1;
      upd_valid = 1'b1;
    end
    for (int s = 0; s < stall; s++) begin
      if (hold) begin
        @(negedge clk);
        chk("bp_req_ready", req_ready, 68'd0);
        chk("bp_upd_ready", upd_ready, 68'd0);
      end
      tick();
      chk_rsp(hit, ifx, pfx, len, tag);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 68'd0);
    if (hit) exp_hits++;
    else exp_misses++;
  endtask

  task automatic do_lookup(input logic [31:0] ip, input logic [7:0] tag, input int stall);
    logic h; logic [3:0] f; logic [31:0] p; logic [7:0] l;
    ref_lookup(ip, h, f, p, l);
    req_dst_ip = ip; req_tag = tag; req_valid = 1'b1;
    wait_grant(1'b0);
    tick();
    req_valid = 1'b0;
    lk_finish(h, f, p, l, tag, stall, 1'b0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_addr_in"}, tcam_addr_in, 68'd0);
    chk({tag, "_wr_en"}, tcam_wr_en, 68'd0);
    chk({tag, "_wr_index"}, tcam_wr_index, 68'd0);
    chk({tag, "_rsp_valid"}, rsp_valid, 68'd0);
    chk({tag, "_rsp_data"}, {rsp_tag, rsp_hit, rsp_if_idx, rsp_prefix, rsp_prefix_len}, 68'd0);
  endtask

`ifdef ROUTE_LOOKUP_STATS_EN
  task automatic chk_stats(input string tag);
    chk({tag, "_hits"}, stat_hits, exp_hits);
    chk({tag, "_misses"}, stat_misses, exp_misses);
    chk({tag, "_updates"}, stat_updates, exp_upd);
  endtask
`endif

  initial begin
    logic h; logic [3:0] f; logic [31:0] p; logic [7:0] l;
    logic [31:0] ip;
    int j;

    rst = 1'b1; rsp_ready = 1'b0;
    req_valid = 1'b1; req_dst_ip = 32'h0A010203; req_tag = 8'h01;
    upd_valid = 1'b1; upd_index = 8'd1; upd_prefix = 32'h0; upd_mask = 32'h0; upd_if_idx = 4'h1;

    // Reset: no grants while held, everything zero after
    tick(); tick();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 68'd0);
    chk("rst_upd_ready", upd_ready, 68'd0);
    tick();
    req_valid = 1'b0; upd_valid = 1'b0; rst = 1'b0;
    chk_zero_outputs("reset");
`ifdef ROUTE_LOOKUP_STATS_EN
    chk_stats("stats_reset");
`endif

    // Update idx 3: 10.0.0.0/8 -> if 2
    upd_index = 8'd3; upd_prefix = 32'h0A000000; upd_mask = 32'hFF000000; upd_if_idx = 4'h2; upd_valid = 1'b1;
    wait_grant(1'b1);
    tick();
    upd_valid = 1'b0;
    chk("upd3_raw_entry", tcam_addr_in, 68'h2_FF000000_0A000000);
    upd_finish(8'd3, 32'h0A000000, 8, 4'h2);

    // Hit on the /8 and a miss
    do_lookup(32'h0A010203, 8'h5A, 0);
    do_lookup(32'hC0A80001, 8'h11, 1);

    // Arbitration: update, lookup, update with both sides pending
    upd_index = 8'd5; upd_prefix = 32'h0A010000; upd_mask = len2mask(16); upd_if_idx = 4'h6; upd_valid = 1'b1;
    req_dst_ip = 32'h0A010203; req_tag = 8'h21; req_valid = 1'b1;
    @(negedge clk);
    chk("arb1_upd_ready", upd_ready, 68'd1);
    chk("arb1_req_ready", req_ready, 68'd0);
    tick();
    upd_index = 8'd6; upd_prefix = 32'hAC100000; upd_mask = len2mask(12); upd_if_idx = 4'h9;
    upd_finish(8'd5, 32'h0A010000, 16, 4'h6);
    @(negedge clk);
    chk("arb2_req_ready", req_ready, 68'd1);
    chk("arb2_upd_ready", upd_ready, 68'd0);
    ref_lookup(32'h0A010203, h, f, p, l);
    tick();
    req_dst_ip = 32'hAC1F0001; req_tag = 8'h22;
    lk_finish(h, f, p, l, 8'h21, 0, 1'b0);
    @(negedge clk);
    chk("arb3_upd_ready", upd_ready, 68'd1);
    chk("arb3_req_ready", req_ready, 68'd0);
    tick();
    upd_valid = 1'b0;
    upd_finish(8'd6, 32'hAC100000, 12, 4'h9);
    ref_lookup(32'hAC1F0001, h, f, p, l);
    wait_grant(1'b0);
    tick();
    req_valid = 1'b0;
    lk_finish(h, f, p, l, 8'h22, 0, 1'b0);

    // Backpressure: 10 stalled cycles with both inputs pending
    ref_lookup(32'h0A010203, h, f, p, l);
    req_dst_ip = 32'h0A010203; req_tag = 8'h66; req_valid = 1'b1;
    wait_grant(1'b0);
    tick();
    req_valid = 1'b0; req_dst_ip = 32'hC0A80001; req_tag = 8'h33;
    upd_index = 8'd9; upd_prefix = 32'hC0A80000; upd_mask = len2mask(16); upd_if_idx = 4'h7;
    lk_finish(h, f, p, l, 8'h66, 10, 1'b1);
    @(negedge clk);
    chk("bp_after_upd", upd_ready, 68'd1);
    chk("bp_after_req", req_ready, 68'd0);
    tick();
    upd_valid = 1'b0;
    upd_finish(8'd9, 32'hC0A80000, 16, 4'h7);
    ref_lookup(32'hC0A80001, h, f, p, l);
    wait_grant(1'b0);
    tick();
    req_valid = 1'b0;
    lk_finish(h, f, p, l, 8'h33, 0, 1'b0);
`ifdef ROUTE_LOOKUP_STATS_EN
    chk_stats("stats_mid");
`endif

    // Reset in the middle of a lookup: dropped, no response
    req_dst_ip = 32'h0A010203; req_tag = 8'h44; req_valid = 1'b1;
    wait_grant(1'b0);
    tick();
    req_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_hits = 0; exp_misses = 0; exp_upd = 0;
    chk_zero_outputs("rst_lookup");
    for (int i = 0; i < int'(LW) + 2; i++) begin
      tick();
      chk("rst_lookup_no_rsp", rsp_valid, 68'd0);
    end
`ifdef ROUTE_LOOKUP_STATS_EN
    chk_stats("stats_rst");
`endif

    // Reset during a write cycle: strobe falls on that edge
    upd_index = 8'd12; upd_prefix = 32'h0B000000; upd_mask = len2mask(8); upd_if_idx = 4'h1; upd_valid = 1'b1;
    wait_grant(1'b1);
    tick();
    upd_valid = 1'b0;
    chk("rst_write_wr_en_hi", tcam_wr_en, 68'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_write_wr_en_lo", tcam_wr_en, 68'd0);
    chk("rst_write_index", tcam_wr_index, 68'd0);
    ref_v[12] = 1'b1; ref_len[12] = 8'd8; ref_pfx[12] = 32'h0B000000; ref_if[12] = 4'h1;
    do_lookup(32'h0B0C0D0E, 8'h77, 0);

    // Randomized mix of updates and lookups
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        int unsigned len;
        len = $urandom_range(1, 32);
        do_update(8'($urandom_range(0, 15)), $urandom & len2mask(len), len, 4'($urandom));
      end else begin
        ip = $urandom;
        j = $urandom_range(0, 15);
        if (ref_v[j] && ($urandom_range(0, 1) == 1)) begin
          ip = ref_pfx[j] | (ip & ~len2mask(int'(ref_len[j])));
        end
        do_lookup(ip, 8'($urandom), $urandom_range(0, 3));
      end
    end
`ifdef ROUTE_LOOKUP_STATS_EN
    chk_stats("stats_final");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
